// File: rtl/onehot_strobe_decoder.sv
// onehot_strobe_decoder: registered 3-to-8 decoder producing timed one-hot strobes.
// Each accepted code drives one output line for (hold+1) cycles. Strobes may run
// back-to-back with no gap, or return to all-zero when no new code is offered.
module onehot_strobe_decoder #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_code,
  input  logic [HOLD_W-1:0] in_hold,
  input  logic              flush,
  output logic [7:0]        out,
  output logic              out_valid,
  output logic              last
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [2:0]          code_q, code_d;
  logic [7:0]          out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                last_q, last_d;
  logic                xfer;

  // Accept a new code when idle or on the final cycle of the current strobe.
  always_comb begin
    in_ready = !flush && ((state_q == IDLE) || (cnt_q == '0));
    xfer     = in_valid && in_ready;
  end

  // Next-state and next-output logic; outputs are derived from the next state
  // so that they can be registered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (xfer) begin
      state_d = DRIVE;
      cnt_d   = in_hold;
      code_d  = in_code;
    end else if (state_q == DRIVE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
    out_d       = (state_d == DRIVE) ? (8'h01 << code_d) : '0;
    out_valid_d = (state_d == DRIVE);
    last_d      = (state_d == DRIVE) && (cnt_d == '0);
  end

  // State, counter, code and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    out       = out_q;
    out_valid = out_valid_q;
    last      = last_q;
  end

endmodule
